// File: rtl/ram_reader_pkg.sv
// rtl/ram_reader_pkg.sv - shared state encoding and widths for the RAM range reader
package ram_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2,
    S_FIN     = 2'd3
  } state_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/ram_reader_addr_counter.sv
// rtl/ram_reader_addr_counter.sv - loadable wrapping address counter (PC-shaped)
module addr_counter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Load wins over increment; increment wraps naturally at 2^ADDR_W.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (inc_i) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/ram_reader.sv
// rtl/ram_reader.sv - scans a RAM address range onto a valid/ready stream
// Optional RAM_READER_CHECKSUM_EN adds a running modular sum of transferred words.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 6,
  parameter int RD_WAIT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [WIDTH-1:0]  mem_out,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
`ifdef RAM_READER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]  checksum
`endif
);

  localparam logic [WAIT_W-1:0] RD_WAIT_V = WAIT_W'(RD_WAIT);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              addr_load, addr_inc;
  logic              xfer;
`ifdef RAM_READER_CHECKSUM_EN
  logic [WIDTH-1:0]  csum_q, csum_d;
`endif

  addr_counter #(.ADDR_W(ADDR_W)) u_addr (
    .clk_i      (clock),
    .reset_i    (reset),
    .load_i     (addr_load),
    .inc_i      (addr_inc),
    .load_val_i (base),
    .addr_o     (mem_address)
  );

  assign xfer = valid_q & data_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    data_d      = data_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    addr_load   = 1'b0;
    addr_inc    = 1'b0;
`ifdef RAM_READER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef RAM_READER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (count != '0) begin
            addr_load   = 1'b1;
            remaining_d = count;
            wait_d      = '0;
            busy_d      = 1'b1;
            state_d     = S_WAIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      // Address is held RD_WAIT full cycles before the capture edge.
      S_WAIT: begin
        if (wait_q == RD_WAIT_V) begin
          data_d  = mem_out;
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_PRESENT: begin
        if (xfer) begin
          valid_d     = 1'b0;
          remaining_d = remaining_q - (ADDR_W+1)'(1);
`ifdef RAM_READER_CHECKSUM_EN
          csum_d      = csum_q + data_q;
`endif
          if (remaining_q == (ADDR_W+1)'(1)) begin
            state_d = S_FIN;
          end else begin
            addr_inc = 1'b1;
            wait_d   = '0;
            state_d  = S_WAIT;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      wait_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef RAM_READER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef RAM_READER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef RAM_READER_CHECKSUM_EN
  assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_ram_reader.sv
// tb/tb_ram_reader.sv - scoreboard bench for ram_reader against a RAM64 model mem[a]=3a+1
module tb_ram_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  base;
  logic [6:0]  count;
  logic [5:0]  mem_address;
  logic [15:0] mem_out;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        done;
`ifdef RAM_READER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  typedef struct {
    logic [5:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  int   xq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  ram_reader #(.WIDTH(16), .ADDR_W(6), .RD_WAIT(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base        (base),
    .count       (count),
    .mem_address (mem_address),
    .mem_out     (mem_out),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .done        (done)
`ifdef RAM_READER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always_comb mem_out = 16'(3 * int'(mem_address) + 1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int a, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.a = 6'(a + i);
      e.d = 16'(3 * int'(e.a) + 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done) begin
        got = 1;
        break;
      end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      if (data_valid) begin
        got = 1;
        break;
      end
      tick();
    end
    chk(name, 32'(got), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every transfer, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        chk("done_busy_low", 32'(busy), 32'd0);
      end
      if (data_valid && data_ready) begin
        xq.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0d expected=none", data_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("word_data", 32'(data_out), 32'(e.d));
          chk("word_addr", 32'(mem_address), 32'(e.a));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; base = '0; count = '0; data_ready = 1'b0;
    repeat (2) tick();
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // Basic scan with latency and cadence.
    push(4, 3);
    xq.delete();
    d0 = done_cnt;
    data_ready = 1'b1; base = 6'd4; count = 7'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_addr", 32'(mem_address), 32'd4);
    tick();
    chk("t1_valid_n1", 32'(data_valid), 32'd0);
    tick();
    chk("t1_valid_n2", 32'(data_valid), 32'd1);
    chk("t1_first_word", 32'(data_out), 32'd13);
    wait_done("t1_done");
    chk("t1_busy_at_done", 32'(busy), 32'd0);
    tick();
    chk("t1_done_width", 32'(done), 32'd0);
    chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t1_nxfer", 32'(xq.size()), 32'd3);
    if (xq.size() == 3) begin
      chk("t1_spacing0", 32'(xq[1] - xq[0]), 32'd3);
      chk("t1_spacing1", 32'(xq[2] - xq[1]), 32'd3);
    end
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Address wrap.
    push(62, 4);
    base = 6'd62; count = 7'd4; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t2_done");
    tick();
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    chk("t2_last_addr", 32'(mem_address), 32'd1);

    // Zero-length scan.
    d0 = done_cnt;
    base = 6'd33; count = 7'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_addr", 32'(mem_address), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_no_valid", 32'(data_valid), 32'd0);
    end
    chk("t3_done_count", 32'(done_cnt - d0), 32'd1);

    // Back-pressure on the second word.
    push(4, 3);
    data_ready = 1'b0; base = 6'd4; count = 7'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("t4_w0_valid");
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    wait_valid("t4_w1_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_data", 32'(data_out), 32'd16);
      chk("t4_hold_valid", 32'(data_valid), 32'd1);
    end
    data_ready = 1'b1;
    wait_done("t4_done");
    tick();
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Start re-pulsed while busy must not relatch.
    push(10, 2);
    base = 6'd10; count = 7'd2; start = 1'b1;
    tick();
    base = 6'd20; count = 7'd5;
    tick();
    tick();
    start = 1'b0;
    wait_done("t5_done");
    tick();
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    chk("t5_last_addr", 32'(mem_address), 32'd11);

    // Reset mid-WAIT, then a fresh scan.
    data_ready = 1'b0; base = 6'd4; count = 7'd3; start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_addr", 32'(mem_address), 32'd0);
    chk("t6_data", 32'(data_out), 32'd0);
    chk("t6_valid", 32'(data_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    push(0, 2);
    data_ready = 1'b1; base = 6'd0; count = 7'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6_done_after");
    tick();
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

`ifdef RAM_READER_CHECKSUM_EN
    push(0, 64);
    base = 6'd0; count = 7'd64; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t7_csum_clear", 32'(checksum), 32'd0);
    wait_done("t7_done");
    chk("t7_checksum", 32'(checksum), 32'd6112);
    tick();
    chk("t7_checksum_hold", 32'(checksum), 32'd6112);
    chk("t7_sb_empty", 32'(sb.size()), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
